// File: rtl/mult_pkg.sv
// Shared constants and types for the arbitrated Booth multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

    // Operand and product widths; B_W is also the Booth iteration count.
    localparam int A_W   = 24;
    localparam int B_W   = 16;
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W);

    // Responder sequencing: grant/load, iterate, publish result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // Selects one of the two initiators (0: envelope, 1: filter).
    typedef logic port_idx_t;

    // One multiply request as carried from a port into the engine.
    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
    } operands_t;

endpackage

// File: rtl/mult_booth_core.sv
// Radix-2 Booth iteration engine: accumulator, shifted multiplicand, B shifter, q bit, counter.
// Latency: load on one edge, then B_W step edges; done_o flags the last step cycle.
// Backpressure: none; the caller only asserts step_i while it owns a loaded operation.
module mult_booth_core
    import mult_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  operands_t        opnd_i,
    output logic             done_o,
    output logic [P_W-1:0]   acc_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

    logic [P_W-1:0]   acc;
    logic [P_W-1:0]   mcand;
    logic [B_W-1:0]   mplier;
    logic             q;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   acc_nxt;

    // Booth recoding of the current pair {B[i], B[i-1]}: add, subtract or hold.
    always_comb begin
        acc_nxt = acc;
        case ({mplier[0], q})
            2'b01:   acc_nxt = acc + mcand;
            2'b10:   acc_nxt = acc - mcand;
            default: acc_nxt = acc;
        endcase
    end

    // Operand load and per-cycle iteration; the multiplicand is kept pre-shifted so
    // each step adds A<<i without a barrel shifter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            q      <= 1'b0;
            cnt    <= '0;
        end else if (load_i) begin
            acc    <= '0;
            mcand  <= {{(P_W - A_W){opnd_i.a[A_W-1]}}, opnd_i.a};
            mplier <= opnd_i.b;
            q      <= 1'b0;
            cnt    <= '0;
        end else if (step_i) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            q      <= mplier[0];
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign done_o = step_i && (cnt == CNT_LAST);
    assign acc_o  = acc;

endmodule

// File: rtl/mult_shared_resp.sv
// Two-port start/ready responder sharing one sequential signed Booth multiplier.
// Latency: readyN_o high in the cycle after the 17th edge following the edge that samples startN_i.
// Backpressure: none; one request held per port, further starts on that port dropped until its ready.
module mult_shared_resp
    import mult_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start0_i,
    input  logic [A_W-1:0]   op_a0_i,
    input  logic [B_W-1:0]   op_b0_i,
    output logic             ready0_o,
    output logic [P_W-1:0]   prod0_o,
    input  logic             start1_i,
    input  logic [A_W-1:0]   op_a1_i,
    input  logic [B_W-1:0]   op_b1_i,
    output logic             ready1_o,
    output logic [P_W-1:0]   prod1_o,
    output logic             busy_o
);

    mult_state_e    state;
    port_idx_t      grant;
    port_idx_t      last_grant;
    logic [1:0]     pend;
    operands_t      opnd_q [2];

    logic [1:0]     start;
    operands_t      opnd_in [2];
    logic [1:0]     req;
    logic           tie;
    logic           grant_vld;
    port_idx_t      grant_nxt;
    operands_t      load_opnd;
    logic [1:0]     served;
    logic [1:0]     capture;

    logic           core_load;
    logic           core_step;
    logic           core_done;
    logic [P_W-1:0] core_acc;

    logic [1:0]     ready_q;
    logic [P_W-1:0] prod_q [2];

    // Arbitration: this cycle's starts count as requests so an idle engine loses no cycle.
    always_comb begin
        start      = {start1_i, start0_i};
        opnd_in[0] = {op_a0_i, op_b0_i};
        opnd_in[1] = {op_a1_i, op_b1_i};
        req        = pend | start;
        tie        = req[0] & req[1];
        grant_vld  = (state == IDLE) && (req != 2'b00);
        grant_nxt  = tie ? ~last_grant : port_idx_t'(req[1]);
        load_opnd  = pend[grant_nxt] ? opnd_q[grant_nxt] : opnd_in[grant_nxt];
    end

    // A start is captured only if the port has nothing pending and is not being served
    // (including being granted straight from its start this cycle).
    always_comb begin
        served  = 2'b00;
        capture = 2'b00;
        for (int i = 0; i < 2; i++) begin
            served[i]  = ((state != IDLE) && (grant == port_idx_t'(i))) ||
                         (grant_vld && (grant_nxt == port_idx_t'(i)));
            capture[i] = start[i] && !pend[i] && !served[i];
        end
    end

    // Pending request slots: first request wins, cleared when the port is granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend      <= 2'b00;
            opnd_q[0] <= '0;
            opnd_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture[i]) begin
                    pend[i]   <= 1'b1;
                    opnd_q[i] <= opnd_in[i];
                end else if (grant_vld && (grant_nxt == port_idx_t'(i))) begin
                    pend[i]   <= 1'b0;
                end
            end
        end
    end

    // Sequencer; last_grant only moves when a tie was actually broken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state <= CALC;
                        grant <= grant_nxt;
                        if (tie) begin
                            last_grant <= grant_nxt;
                        end
                    end
                end
                CALC: begin
                    if (core_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign core_load = grant_vld;
    assign core_step = (state == CALC);

    mult_booth_core u_core (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (core_load),
        .step_i (core_step),
        .opnd_i (load_opnd),
        .done_o (core_done),
        .acc_o  (core_acc)
    );

    // Result publication: only the granted port's product register and ready pulse change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q   <= 2'b00;
            prod_q[0] <= '0;
            prod_q[1] <= '0;
        end else begin
            ready_q <= 2'b00;
            if (state == DONE) begin
                ready_q[grant] <= 1'b1;
                prod_q[grant]  <= core_acc;
            end
        end
    end

    assign ready0_o = ready_q[0];
    assign ready1_o = ready_q[1];
    assign prod0_o  = prod_q[0];
    assign prod1_o  = prod_q[1];
    assign busy_o   = (state != IDLE) || (pend != 2'b00);

endmodule

// File: tb/tb_mult_shared_resp.sv
// Self-checking bench for the shared two-port Booth multiplier.
// Latency: directed sequences check exact ready timing; random traffic checks bounded completion.
// Backpressure: extra starts on an outstanding port are injected and must be dropped.
module tb_mult_shared_resp;
    import mult_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           start0, start1;
    logic [A_W-1:0] a0, a1;
    logic [B_W-1:0] b0, b1;
    logic           ready0, ready1, busy;
    logic [P_W-1:0] prod0, prod1;

    always #5 clk = ~clk;

    mult_shared_resp dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start0_i (start0),
        .op_a0_i  (a0),
        .op_b0_i  (b0),
        .ready0_o (ready0),
        .prod0_o  (prod0),
        .start1_i (start1),
        .op_a1_i  (a1),
        .op_b1_i  (b1),
        .ready1_o (ready1),
        .prod1_o  (prod1),
        .busy_o   (busy)
    );

    int     n_tot  = 0;
    int     n_pass = 0;
    int     first_r [2];
    int     cnt_r   [2];
    longint got_p   [2];
    longint exp_last[2];

    typedef struct {
        int     port;
        longint a;
        longint b;
        longint prod;
    } vec_t;
    vec_t vecs[8];

    longint                expq[2][$];
    int                    age[2];
    int                    issued[2];
    int                    done_n[2];
    int                    cyc;
    logic                  r_now;
    longint                p_now;
    logic signed [A_W-1:0] ta;
    logic signed [B_W-1:0] tb;
    longint                ra, rb;
    localparam int N_RAND = 800;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic drive(input int p, input longint a, input longint b);
        if (p == 0) begin
            start0 = 1'b1; a0 = A_W'(a); b0 = B_W'(b);
        end else begin
            start1 = 1'b1; a1 = A_W'(a); b1 = B_W'(b);
        end
    endtask

    task automatic obs_clear();
        for (int i = 0; i < 2; i++) begin
            first_r[i] = -1; cnt_r[i] = 0; got_p[i] = 0;
        end
    endtask

    // Record ready pulses seen at relative cycle k (k=0 is just after the sampling edge).
    task automatic obs(input int k);
        if (ready0 === 1'b1) begin
            cnt_r[0]++; got_p[0] = longint'($signed(prod0));
            if (first_r[0] < 0) first_r[0] = k;
        end
        if (ready1 === 1'b1) begin
            cnt_r[1]++; got_p[1] = longint'($signed(prod1));
            if (first_r[1] < 0) first_r[1] = k;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_last[0] = 0; exp_last[1] = 0;
    endtask

    // Uncontended single multiply: exact latency, single pulse, product, other port untouched.
    task automatic single(input int p, input longint a, input longint b, input longint exp, input string nm);
        drive(p, a, b);
        obs_clear();
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            obs(k);
            if (k == 0) begin start0 = 1'b0; start1 = 1'b0; end
            if (k == 5) chk({nm, " busy"}, longint'(busy), 1);
        end
        chk({nm, " latency"}, longint'(first_r[p]), 17);
        chk({nm, " pulses"}, longint'(cnt_r[p]), 1);
        chk({nm, " prod"}, got_p[p], exp);
        chk({nm, " other ready"}, longint'(cnt_r[1-p]), 0);
        chk({nm, " other prod"}, longint'($signed((p == 0) ? prod1 : prod0)), exp_last[1-p]);
        exp_last[p] = exp;
    endtask

    // Simultaneous starts: 'first' must be served first, the other 18 cycles later.
    task automatic tie_seq(input int first, input longint xa0, input longint xb0,
                           input longint xa1, input longint xb1, input string nm);
        drive(0, xa0, xb0);
        drive(1, xa1, xb1);
        obs_clear();
        for (int k = 0; k <= 44; k++) begin
            @(negedge clk);
            obs(k);
            if (k == 0) begin start0 = 1'b0; start1 = 1'b0; end
        end
        chk({nm, " first latency"}, longint'(first_r[first]), 17);
        chk({nm, " second latency"}, longint'(first_r[1-first]), 35);
        chk({nm, " pulses p0"}, longint'(cnt_r[0]), 1);
        chk({nm, " pulses p1"}, longint'(cnt_r[1]), 1);
        chk({nm, " prod p0"}, got_p[0], xa0 * xb0);
        chk({nm, " prod p1"}, got_p[1], xa1 * xb1);
        exp_last[0] = xa0 * xb0; exp_last[1] = xa1 * xb1;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        vecs[0] = '{0, 1000, 200, 200000};
        vecs[1] = '{0, -8388608, -32768, 64'sd274877906944};
        vecs[2] = '{1, -5, 7, -35};
        vecs[3] = '{0, 8388607, -1, -8388607};
        vecs[4] = '{1, 0, -32768, 0};
        vecs[5] = '{1, -1, -1, 1};
        vecs[6] = '{0, -8388608, 32767, -64'sd274869518336};
        vecs[7] = '{1, 8388607, 32767, 64'sd274869485569};

        // Reset state
        @(negedge clk);
        do_reset();
        chk("reset ready0", longint'(ready0), 0);
        chk("reset ready1", longint'(ready1), 0);
        chk("reset prod0", longint'(prod0), 0);
        chk("reset prod1", longint'(prod1), 0);
        chk("reset busy", longint'(busy), 0);

        // Table-driven single operations, signs and extremes
        for (int i = 0; i < 8; i++)
            single(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));

        // Ties after reset, then a repeated tie goes the other way
        do_reset();
        tie_seq(0, 1234, -56, -789, 321, "tie1");
        tie_seq(1, -42, 42, 65535, -2, "tie2");

        // Port 1 requests while port 0 is busy; the second start1 must be dropped
        drive(0, 3000, -7);
        obs_clear();
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            obs(k);
            if (k == 0) start0 = 1'b0;
            if (k == 4) drive(1, 111, -222);
            if (k == 5) start1 = 1'b0;
            if (k == 7) drive(1, 999, 999);
            if (k == 8) start1 = 1'b0;
            if (k == 20) chk("cap busy", longint'(busy), 1);
        end
        chk("cap p0 latency", longint'(first_r[0]), 17);
        chk("cap p1 latency", longint'(first_r[1]), 35);
        chk("cap p0 pulses", longint'(cnt_r[0]), 1);
        chk("cap p1 pulses", longint'(cnt_r[1]), 1);
        chk("cap p0 prod", got_p[0], -21000);
        chk("cap p1 prod", got_p[1], -24642);

        // Reset during CALC iteration 9 with port 1 pending
        drive(0, 12345, -321);
        obs_clear();
        for (int k = 0; k <= 44; k++) begin
            @(negedge clk);
            obs(k);
            if (k == 10) begin
                chk("abort prod0", longint'(prod0), 0);
                chk("abort prod1", longint'(prod1), 0);
                chk("abort busy", longint'(busy), 0);
            end
            if (k == 0) start0 = 1'b0;
            if (k == 2) drive(1, 77, 88);
            if (k == 3) start1 = 1'b0;
            if (k == 9) rst = 1'b1;
            if (k == 10) rst = 1'b0;
        end
        chk("abort ready0 pulses", longint'(cnt_r[0]), 0);
        chk("abort ready1 pulses", longint'(cnt_r[1]), 0);
        chk("abort busy idle", longint'(busy), 0);
        exp_last[0] = 0; exp_last[1] = 0;
        single(0, -5, 7, -35, "post abort");

        // Random traffic on both ports against a per-port outstanding-request scoreboard
        for (int p = 0; p < 2; p++) begin
            age[p] = 0; issued[p] = 0; done_n[p] = 0; expq[p].delete();
        end
        cyc = 0;
        while ((issued[0] < N_RAND || issued[1] < N_RAND ||
                expq[0].size() != 0 || expq[1].size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < 2; p++) begin
                r_now = (p == 0) ? ready0 : ready1;
                p_now = longint'($signed((p == 0) ? prod0 : prod1));
                if (r_now === 1'b1) begin
                    if (expq[p].size() == 0) begin
                        chk($sformatf("rand p%0d spurious ready", p), 1, 0);
                    end else begin
                        chk($sformatf("rand p%0d prod", p), p_now, expq[p].pop_front());
                        done_n[p]++;
                    end
                end else if (expq[p].size() != 0) begin
                    age[p]++;
                    if (age[p] > 60) begin
                        chk($sformatf("rand p%0d timeout", p), longint'(age[p]), 60);
                        expq[p].delete();
                    end
                end
                if (expq[p].size() == 0 && issued[p] < N_RAND && $urandom_range(0, 2) == 0) begin
                    ta = A_W'($urandom);
                    tb = B_W'($urandom);
                    if ($urandom_range(0, 15) == 0) ta = {1'b1, {(A_W-1){1'b0}}};
                    if ($urandom_range(0, 15) == 0) tb = {1'b1, {(B_W-1){1'b0}}};
                    ra = ta; rb = tb;
                    drive(p, ra, rb);
                    expq[p].push_back(ra * rb);
                    issued[p]++;
                    age[p] = 0;
                end else if (expq[p].size() != 0 && $urandom_range(0, 5) == 0) begin
                    drive(p, longint'($urandom), longint'($urandom));
                end else begin
                    if (p == 0) start0 = 1'b0; else start1 = 1'b0;
                end
            end
        end
        chk("rand within budget", longint'(cyc < 60000), 1);
        chk("rand p0 completions", longint'(done_n[0]), N_RAND);
        chk("rand p1 completions", longint'(done_n[1]), N_RAND);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
